// File: rtl/dft_bus_master.sv
// dft_bus_master: streams 8-sample frames into a memory-mapped DFT block
// (registers BASE..BASE+7) and then reads 8 results back out.
// Build option: define DFT_MASTER_FRAMECNT_EN to get a wrapping 8-bit count
// of completed frames on frame_count. Without it, frame_count is tied to 0.
module dft_bus_master #(
  parameter int unsigned      WIDTH = 8,
  parameter logic [WIDTH-1:0] BASE  = 8'hF8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             memwrite,
  output logic [WIDTH-1:0] adr,
  output logic [WIDTH-1:0] writedata,
  input  logic [WIDTH-1:0] memdata,
  output logic             busy,
  output logic             frame_done,
  output logic [7:0]       frame_count
);

  typedef enum logic [2:0] {IDLE, LOAD, FLUSH, SETTLE, READ, DONE} state_t;

  state_t           state_q;
  logic [2:0]       widx_q;
  logic [2:0]       ridx_q;
  logic             memwrite_q;
  logic [WIDTH-1:0] adr_q;
  logic [WIDTH-1:0] writedata_q;
  logic [WIDTH-1:0] out_data_q;
  logic             out_valid_q;
  logic             busy_q;
  logic             frame_done_q;

  // Bus address of DFT register idx; wraps modulo 2^WIDTH.
  function automatic logic [WIDTH-1:0] bus_addr(input logic [2:0] idx);
    return BASE + WIDTH'(idx);
  endfunction

  // Frame sequencer with all bus/stream outputs registered.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      widx_q       <= 3'd0;
      ridx_q       <= 3'd0;
      memwrite_q   <= 1'b0;
      adr_q        <= BASE;
      writedata_q  <= '0;
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      // Strobes default low; a pending result drops once consumed unless a
      // fresh capture below replaces it on the same edge.
      memwrite_q   <= 1'b0;
      frame_done_q <= 1'b0;
      if (out_valid_q && out_ready) out_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          widx_q  <= 3'd0;
          ridx_q  <= 3'd0;
          busy_q  <= 1'b0;
          state_q <= LOAD;
        end
        LOAD: begin
          if (in_valid) begin
            memwrite_q  <= 1'b1;
            adr_q       <= bus_addr(widx_q);
            writedata_q <= in_data;
            widx_q      <= widx_q + 3'd1;
            busy_q      <= 1'b1;
            if (widx_q == 3'd7) state_q <= FLUSH;
          end
        end
        FLUSH: begin
          // The last write is on the bus this cycle; point at register 0
          // so the address is settled well before the first read.
          adr_q   <= bus_addr(3'd0);
          state_q <= SETTLE;
        end
        SETTLE: begin
          state_q <= READ;
        end
        READ: begin
          if (!out_valid_q || out_ready) begin
            out_data_q  <= memdata;
            out_valid_q <= 1'b1;
            ridx_q      <= ridx_q + 3'd1;
            adr_q       <= bus_addr(ridx_q + 3'd1);
            if (ridx_q == 3'd7) begin
              state_q      <= DONE;
              frame_done_q <= 1'b1;
            end
          end
        end
        DONE: begin
          widx_q  <= 3'd0;
          ridx_q  <= 3'd0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign in_ready   = (state_q == LOAD);
  assign memwrite   = memwrite_q;
  assign adr        = adr_q;
  assign writedata  = writedata_q;
  assign out_data   = out_data_q;
  assign out_valid  = out_valid_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;

`ifdef DFT_MASTER_FRAMECNT_EN
  logic [7:0] frame_count_q;

  // Completed-frame counter, advancing on the edge that leaves DONE.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_count_q <= 8'd0;
    end else if (state_q == DONE) begin
      frame_count_q <= frame_count_q + 8'd1;
    end
  end

  assign frame_count = frame_count_q;
`else
  assign frame_count = 8'd0;
`endif

endmodule

// File: tb/tb_dft_bus_master.sv
// Bench for dft_bus_master with a behavioural DFT slave whose read data comes
// from an output register one clock behind its write registers.
module tb_dft_bus_master;

  localparam logic [7:0] BASE = 8'hF8;
`ifdef DFT_MASTER_FRAMECNT_EN
  localparam bit FC_EN = 1'b1;
`else
  localparam bit FC_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       memwrite;
  logic [7:0] adr;
  logic [7:0] writedata;
  logic [7:0] memdata;
  logic       busy;
  logic       frame_done;
  logic [7:0] frame_count;

  dft_bus_master #(.WIDTH(8), .BASE(8'hF8)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .memwrite    (memwrite),
    .adr         (adr),
    .writedata   (writedata),
    .memdata     (memdata),
    .busy        (busy),
    .frame_done  (frame_done),
    .frame_count (frame_count)
  );

  always #5 clk = ~clk;

  // DFT slave: writes land in dft_in, results appear in dft_out one edge later.
  logic [7:0] dft_in  [8];
  logic [7:0] dft_out [8];
  always @(posedge clk) begin
    if (memwrite && adr[7:3] == 5'b11111) dft_in[adr[2:0]] <= writedata;
    dft_out <= dft_in;
  end
  assign memdata = (adr[7:3] == 5'b11111) ? dft_out[adr[2:0]] : 8'h00;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;
  logic [15:0] wrq[$];
  logic [7:0]  rdq[$];
  int last_accept = 0;
  int last_rise = 0;
  logic ov_prev = 1'b0;
  int done_cnt = 0;
  int nframes = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Scoreboard monitor: bus writes and consumed results against the queues.
  always @(negedge clk) begin
    logic [15:0] w;
    if (memwrite) begin
      chk("wr_pending", 32'(wrq.size() != 0), 1);
      if (wrq.size() != 0) begin
        w = wrq.pop_front();
        chk("wr_adr", adr, w[15:8]);
        chk("wr_data", writedata, w[7:0]);
      end
    end
    if (out_valid && out_ready) begin
      chk("rd_pending", 32'(rdq.size() != 0), 1);
      if (rdq.size() != 0) chk("out_data", out_data, rdq.pop_front());
    end
    if (out_valid && !ov_prev) last_rise = cyc;
    ov_prev = out_valid;
    if (frame_done) done_cnt++;
  end

  task automatic wait_ready();
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 64) begin
      @(negedge clk);
      n++;
    end
    chk("in_ready_wait", 32'(in_ready), 1);
  endtask

  // Offer n samples first, first+1, ...; optional in_valid gap before sample gap_at.
  task automatic send(input logic [7:0] first, input int n, input int gap_at, input int gap_len);
    for (int i = 0; i < n; i++) begin
      if (i == gap_at) begin
        in_valid = 1'b0;
        repeat (gap_len) @(posedge clk);
        #1;
      end
      in_data  = first + 8'(i);
      in_valid = 1'b1;
      wait_ready();
      wrq.push_back({BASE + 8'(i), first + 8'(i)});
      rdq.push_back(first + 8'(i));
      @(posedge clk);
      #1;
      last_accept = cyc;
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    @(negedge clk);
    while ((rdq.size() != 0 || out_valid) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain_rdq", rdq.size(), 0);
    chk("drain_wrq", wrq.size(), 0);
    nframes++;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, observed time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    out_ready = 1'b1;
    #23;
    // Reset state
    chk("rst_memwrite", memwrite, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_adr", adr, 8'hF8);
    chk("rst_writedata", writedata, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_frame_count", frame_count, 0);
    @(negedge clk);
    reset_n = 1'b1;
    chk("post_rel_in_ready", in_ready, 0);
    @(posedge clk);
    #1;
    chk("post_rel_busy", busy, 0);

    // Back-to-back frame, out_ready high
    send(8'h10, 8, -1, 0);
    drain();
    chk("latency", 32'(last_rise - last_accept), 3);
    chk("frame_count_1", frame_count, FC_EN ? 32'(nframes) : 0);

    // Two-cycle in_valid gap between samples 3 and 4
    send(8'h10, 8, 4, 2);
    drain();
    chk("frame_count_2", frame_count, FC_EN ? 32'(nframes) : 0);

    // Downstream stall of 5 cycles after the first result
    out_ready = 1'b0;
    send(8'h10, 8, -1, 0);
    begin
      int n = 0;
      @(negedge clk);
      while (!out_valid && n < 20) begin
        @(negedge clk);
        n++;
      end
    end
    chk("stall_valid", out_valid, 1);
    for (int k = 0; k < 5; k++) begin
      chk("stall_out_data", out_data, 8'h10);
      chk("stall_adr", adr, 8'hF9);
      chk("stall_busy", busy, 1);
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    drain();
    chk("frame_count_3", frame_count, FC_EN ? 32'(nframes) : 0);
    chk("done_pulses_3", done_cnt, 32'(nframes));

    // Reset after three accepts
    send(8'h50, 3, -1, 0);
    chk("pre_rst_memwrite", memwrite, 1);
    reset_n = 1'b0;
    #1;
    chk("async_memwrite", memwrite, 0);
    chk("async_adr", adr, 8'hF8);
    chk("async_busy", busy, 0);
    chk("async_in_ready", in_ready, 0);
    wrq.delete();
    rdq.delete();
    repeat (2) @(negedge clk);
    reset_n  = 1'b1;
    nframes  = 0;
    done_cnt = 0;
    send(8'hA0, 8, -1, 0);
    drain();
    chk("frame_count_after_rst", frame_count, FC_EN ? 32'(nframes) : 0);

`ifdef DFT_MASTER_FRAMECNT_EN
    // Counter wrap: 256 then 257 frames from a fresh reset
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n  = 1'b1;
    nframes  = 0;
    done_cnt = 0;
    for (int f = 0; f < 256; f++) begin
      send(8'(f), 8, -1, 0);
      drain();
    end
    chk("frame_count_256", frame_count, 8'h00);
    send(8'h33, 8, -1, 0);
    drain();
    chk("frame_count_257", frame_count, 8'h01);
    chk("done_pulses_257", done_cnt, 257);
`else
    chk("done_pulses_final", done_cnt, 32'(nframes));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
